alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of general registers (2..16); sets Rin/Rout width.
REQ-002 SHALL have parameter MULDIV_CYCLES, default 1, ALU cycles held for MUL/DIV (1..32).
REQ-003 SHALL have port clock, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port clear, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to run one fetch+execute sequence.
REQ-006 SHALL have port ir, input, 32, IR contents; opcode=ir[31:27], ra=ir[26:23] (dest), rb=ir[22:19], rc=ir[18:15].
REQ-007 SHALL have outputs PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, ALU_MUL, ALU_DIV, each 1 bit, datapath strobes.
REQ-008 SHALL have outputs Rin and Rout, each NUM_REGS bits, one-hot register select.
REQ-009 SHALL have output ALUop, 4 bits, ALU function select.
REQ-010 SHALL have outputs busy, done and illegal, each 1 bit, status.

Function
REQ-011 SHALL be a Moore FSM: states IDLE, T0, T1, T2, T3, T4, WAIT, T5, T6; every output decodes from the state register (plus ir fields) only.
REQ-012 SHALL leave IDLE for T0 on a clock edge with start=1; start SHALL be ignored in every other state.
REQ-013 T0: PCout, MARin, IncPC, Zlowin=1; next T1.
REQ-014 T1: Zlowout, PCin, Read, MDRin=1; next T2.
REQ-015 T2: MDRout, IRin=1; next T3.
REQ-016 T3: Rout[rb]=1, Yin=1; decode ir; if opcode>13, or ra, rb or rc >= NUM_REGS, raise illegal for this cycle and go to IDLE; else go to T4.
REQ-017 Opcodes 0..11 (ALU class): T4 drives Rout[rc]=1, ALUop=opcode[3:0], Zlowin=1; next T5.
REQ-018 Opcodes 12 (MUL) and 13 (DIV): T4 drives Rout[rc]=1 and ALU_MUL (12) or ALU_DIV (13); if MULDIV_CYCLES=1, T4 also drives Zlowin and Zhighin and goes to T5, else it goes to WAIT.
REQ-019 WAIT SHALL hold Rout[rc] and ALU_MUL/ALU_DIV for MULDIV_CYCLES-1 further cycles using a down-counter loaded in T4; Zlowin and Zhighin are asserted only in its final cycle; next T5.
REQ-020 T5, ALU class: Zlowout=1, Rin[ra]=1, done=1; next IDLE.
REQ-021 T5, MUL/DIV: Zlowout=1, LOin=1; next T6. T6: Zhighout=1, HIin=1, done=1; next IDLE.
REQ-022 busy SHALL be 1 in every state except IDLE; done and illegal SHALL be single-cycle pulses and never high together.
REQ-023 Rin and Rout SHALL never have more than one bit set, and SHALL never be nonzero in the same cycle.
REQ-024 Every strobe not listed for a state SHALL be 0 in that state; ALUop SHALL be 0 outside T4.
REQ-025 A back-to-back request (start=1 during the done cycle) SHALL enter T0 on the edge after return to IDLE, with one IDLE cycle in between.

Reset
REQ-026 clear=1 SHALL force IDLE immediately without waiting for a clock edge, in any state including WAIT.
REQ-027 While clear=1, all outputs SHALL be 0, including busy, done, illegal, Rin, Rout and ALUop.
REQ-028 The first start is accepted on the first rising edge after clear deasserts.
REQ-029 A sequence interrupted by clear SHALL NOT resume; no Rin, HIin or LOin pulse may occur after clear rises.

Verification
REQ-030 shr R7,R0,R4 test: ir=opcode 5, ra=7, rb=0, rc=4; R0=0x34, R4=2; pulse start -> T0..T5 in 6 cycles; Rin[7] and done in T5; datapath R7=0x0000000D.
REQ-031 MUL test: MULDIV_CYCLES=1, R2=0x10000, R3=0x10000, opcode 12 -> LOin in T5, HIin in T6; LO=0x00000000, HI=0x00000001; done in T6 only.
REQ-032 DIV latency test: MULDIV_CYCLES=4, R2=17, R3=5, opcode 13 -> ALU_DIV high for 4 consecutive cycles; Zlowin/Zhighin only in the 4th cycle; LO=3, HI=2.
REQ-033 Illegal test: opcode 20 -> illegal pulse in T3; no Rin bit ever set; back in IDLE at the next cycle. Repeat with NUM_REGS=8 and ra=9 -> same response.
REQ-034 Reset test: assert clear mid-WAIT, asynchronously between clock edges -> outputs 0 and busy=0 before the next edge; no LOin or HIin follows.
REQ-035 Throughput test: hold start=1 continuously -> busy low exactly one cycle between sequences; Rin/Rout one-hot and mutually exclusive in every cycle.

Source files
------------

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Moore control sequencer for fetch + execute of ALU, MUL and DIV
//                instructions. It drives one-hot register strobes and
//                datapath strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int NUM_REGS      = 16,
    parameter int MULDIV_CYCLES = 1
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic [31:0]         ir,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zlowin,
    output logic                Zhighin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic                ALU_MUL,
    output logic                ALU_DIV,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [3:0]          ALUop,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    localparam logic [3:0] c_S_IDLE = 4'd0;
    localparam logic [3:0] c_S_T0   = 4'd1;
    localparam logic [3:0] c_S_T1   = 4'd2;
    localparam logic [3:0] c_S_T2   = 4'd3;
    localparam logic [3:0] c_S_T3   = 4'd4;
    localparam logic [3:0] c_S_T4   = 4'd5;
    localparam logic [3:0] c_S_WAIT = 4'd6;
    localparam logic [3:0] c_S_T5   = 4'd7;
    localparam logic [3:0] c_S_T6   = 4'd8;

    localparam logic [NUM_REGS-1:0] c_ONE          = {{(NUM_REGS-1){1'b0}}, 1'b1};
    localparam logic [4:0]          c_NREGS        = 5'(NUM_REGS);
    localparam logic                c_MULDIV_MULTI = (MULDIV_CYCLES > 1);
    // WAIT lasts MULDIV_CYCLES-1 cycles; the counter reaches zero in its final cycle
    localparam logic [4:0]          c_WAIT_LOAD    = (MULDIV_CYCLES >= 2) ? 5'(MULDIV_CYCLES - 2) : 5'd0;

    logic [3:0]          r_state;
    logic [4:0]          r_wait_cnt;

    logic [4:0]          w_opcode;
    logic [3:0]          w_ra;
    logic [3:0]          w_rb;
    logic [3:0]          w_rc;
    logic                w_is_muldiv;
    logic                w_is_div;
    logic                w_bad;
    logic                w_last_wait;
    logic [NUM_REGS-1:0] w_sel_ra;
    logic [NUM_REGS-1:0] w_sel_rb;
    logic [NUM_REGS-1:0] w_sel_rc;
    logic                w_unused_ir;

    assign w_opcode    = ir[31:27];
    assign w_ra        = ir[26:23];
    assign w_rb        = ir[22:19];
    assign w_rc        = ir[18:15];
    assign w_unused_ir = ^ir[14:0];

    assign w_is_muldiv = (w_opcode == 5'd12) || (w_opcode == 5'd13);
    assign w_is_div    = (w_opcode == 5'd13);
    assign w_bad       = (w_opcode > 5'd13) ||
                         ({1'b0, w_ra} >= c_NREGS) ||
                         ({1'b0, w_rb} >= c_NREGS) ||
                         ({1'b0, w_rc} >= c_NREGS);
    assign w_last_wait = (r_wait_cnt == 5'd0);

    // Shifting past the top bit yields zero, so out-of-range fields select nothing
    assign w_sel_ra = c_ONE << w_ra;
    assign w_sel_rb = c_ONE << w_rb;
    assign w_sel_rc = c_ONE << w_rc;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state    <= c_S_IDLE;
            r_wait_cnt <= 5'd0;
        end else begin
            case (r_state)
                c_S_IDLE: if (start) r_state <= c_S_T0;
                c_S_T0:   r_state <= c_S_T1;
                c_S_T1:   r_state <= c_S_T2;
                c_S_T2:   r_state <= c_S_T3;
                c_S_T3:   r_state <= w_bad ? c_S_IDLE : c_S_T4;
                c_S_T4: begin
                    if (w_is_muldiv && c_MULDIV_MULTI) begin
                        r_state    <= c_S_WAIT;
                        r_wait_cnt <= c_WAIT_LOAD;
                    end else begin
                        r_state <= c_S_T5;
                    end
                end
                c_S_WAIT: begin
                    if (w_last_wait) r_state <= c_S_T5;
                    else             r_wait_cnt <= r_wait_cnt - 5'd1;
                end
                c_S_T5:   r_state <= w_is_muldiv ? c_S_T6 : c_S_IDLE;
                c_S_T6:   r_state <= c_S_IDLE;
                default:  r_state <= c_S_IDLE;
            endcase
        end
    end

    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowin   = 1'b0;
        Zhighin  = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        ALU_MUL  = 1'b0;
        ALU_DIV  = 1'b0;
        Rin      = '0;
        Rout     = '0;
        ALUop    = 4'd0;
        done     = 1'b0;
        illegal  = 1'b0;
        busy     = (r_state != c_S_IDLE);
        case (r_state)
            c_S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            c_S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            c_S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            c_S_T3: begin
                Rout    = w_sel_rb;
                Yin     = 1'b1;
                illegal = w_bad;
            end
            c_S_T4: begin
                Rout = w_sel_rc;
                if (w_is_muldiv) begin
                    ALU_MUL = ~w_is_div;
                    ALU_DIV = w_is_div;
                    Zlowin  = ~c_MULDIV_MULTI;
                    Zhighin = ~c_MULDIV_MULTI;
                end else begin
                    ALUop  = w_opcode[3:0];
                    Zlowin = 1'b1;
                end
            end
            c_S_WAIT: begin
                Rout    = w_sel_rc;
                ALU_MUL = ~w_is_div;
                ALU_DIV = w_is_div;
                Zlowin  = w_last_wait;
                Zhighin = w_last_wait;
            end
            c_S_T5: begin
                Zlowout = 1'b1;
                if (w_is_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    Rin  = w_sel_ra;
                    done = 1'b1;
                end
            end
            c_S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Bench for alu_op_sequencer with two parameterisations
//                (16 regs / 1-cycle MUL-DIV and 8 regs / 4-cycle MUL-DIV).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;

    typedef struct packed {
        logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
        logic zlo_in, zhi_in, zlo_out, zhi_out, hi_in, lo_in, alu_mul, alu_div;
        logic busy, done, illegal;
        logic [3:0]  alu_op;
        logic [15:0] rin;
        logic [15:0] rout;
    } out_t;
    typedef out_t trace_t[$];

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [31:0] ir    = 32'h0;

    int errors = 0;
    int checks = 0;

    logic PCout_0, MARin_0, IncPC_0, PCin_0, Read_0, MDRin_0, MDRout_0, IRin_0, Yin_0, Zlowin_0;
    logic Zhighin_0, Zlowout_0, Zhighout_0, HIin_0, LOin_0, ALU_MUL_0, ALU_DIV_0, busy_0, done_0, illegal_0;
    logic PCout_1, MARin_1, IncPC_1, PCin_1, Read_1, MDRin_1, MDRout_1, IRin_1, Yin_1, Zlowin_1;
    logic Zhighin_1, Zlowout_1, Zhighout_1, HIin_1, LOin_1, ALU_MUL_1, ALU_DIV_1, busy_1, done_1, illegal_1;
    logic [15:0] Rin_0, Rout_0;
    logic [7:0]  Rin_1, Rout_1;
    logic [3:0]  ALUop_0, ALUop_1;

    always #5 clock = ~clock;

    alu_op_sequencer dut0 (
        .clock(clock), .clear(clear), .start(start), .ir(ir),
        .PCout(PCout_0), .MARin(MARin_0), .IncPC(IncPC_0), .PCin(PCin_0), .Read(Read_0),
        .MDRin(MDRin_0), .MDRout(MDRout_0), .IRin(IRin_0), .Yin(Yin_0), .Zlowin(Zlowin_0),
        .Zhighin(Zhighin_0), .Zlowout(Zlowout_0), .Zhighout(Zhighout_0), .HIin(HIin_0),
        .LOin(LOin_0), .ALU_MUL(ALU_MUL_0), .ALU_DIV(ALU_DIV_0), .Rin(Rin_0), .Rout(Rout_0),
        .ALUop(ALUop_0), .busy(busy_0), .done(done_0), .illegal(illegal_0)
    );

    alu_op_sequencer #(.NUM_REGS(8), .MULDIV_CYCLES(4)) dut1 (
        .clock(clock), .clear(clear), .start(start), .ir(ir),
        .PCout(PCout_1), .MARin(MARin_1), .IncPC(IncPC_1), .PCin(PCin_1), .Read(Read_1),
        .MDRin(MDRin_1), .MDRout(MDRout_1), .IRin(IRin_1), .Yin(Yin_1), .Zlowin(Zlowin_1),
        .Zhighin(Zhighin_1), .Zlowout(Zlowout_1), .Zhighout(Zhighout_1), .HIin(HIin_1),
        .LOin(LOin_1), .ALU_MUL(ALU_MUL_1), .ALU_DIV(ALU_DIV_1), .Rin(Rin_1), .Rout(Rout_1),
        .ALUop(ALUop_1), .busy(busy_1), .done(done_1), .illegal(illegal_1)
    );

    out_t obs [2];
    assign obs[0] = {PCout_0, MARin_0, IncPC_0, PCin_0, Read_0, MDRin_0, MDRout_0, IRin_0, Yin_0,
                     Zlowin_0, Zhighin_0, Zlowout_0, Zhighout_0, HIin_0, LOin_0, ALU_MUL_0, ALU_DIV_0,
                     busy_0, done_0, illegal_0, ALUop_0, Rin_0, Rout_0};
    assign obs[1] = {PCout_1, MARin_1, IncPC_1, PCin_1, Read_1, MDRin_1, MDRout_1, IRin_1, Yin_1,
                     Zlowin_1, Zhighin_1, Zlowout_1, Zhighout_1, HIin_1, LOin_1, ALU_MUL_1, ALU_DIV_1,
                     busy_1, done_1, illegal_1, ALUop_1, {8'h00, Rin_1}, {8'h00, Rout_1}};

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'h0};
    endfunction

    function automatic logic [15:0] sel(input int idx, input int nregs);
        return (idx < nregs) ? 16'(1 << idx) : 16'h0000;
    endfunction

    // Whole expected strobe sequence of one instruction, one entry per cycle from T0
    function automatic trace_t build(input logic [31:0] irv, input int nregs, input int mdc);
        trace_t t;
        out_t   e;
        int op = int'(irv[31:27]);
        int ra = int'(irv[26:23]);
        int rb = int'(irv[22:19]);
        int rc = int'(irv[18:15]);
        bit bad = (op > 13) || (ra >= nregs) || (rb >= nregs) || (rc >= nregs);
        e = '0; e.busy = 1; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.zlo_in = 1; t.push_back(e);
        e = '0; e.busy = 1; e.zlo_out = 1; e.pc_in = 1; e.read = 1; e.mdr_in = 1;   t.push_back(e);
        e = '0; e.busy = 1; e.mdr_out = 1; e.ir_in = 1;                              t.push_back(e);
        e = '0; e.busy = 1; e.rout = sel(rb, nregs); e.y_in = 1; e.illegal = bad;    t.push_back(e);
        if (bad) return t;
        if (op < 12) begin
            e = '0; e.busy = 1; e.rout = sel(rc, nregs); e.alu_op = 4'(op); e.zlo_in = 1; t.push_back(e);
            e = '0; e.busy = 1; e.zlo_out = 1; e.rin = sel(ra, nregs); e.done = 1;       t.push_back(e);
        end else begin
            for (int i = 0; i < mdc; i++) begin
                e = '0; e.busy = 1; e.rout = sel(rc, nregs);
                e.alu_mul = (op == 12); e.alu_div = (op == 13);
                e.zlo_in = (i == mdc - 1); e.zhi_in = (i == mdc - 1);
                t.push_back(e);
            end
            e = '0; e.busy = 1; e.zlo_out = 1; e.lo_in = 1;          t.push_back(e);
            e = '0; e.busy = 1; e.zhi_out = 1; e.hi_in = 1; e.done = 1; t.push_back(e);
        end
        return t;
    endfunction

    trace_t q0, q1;

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            q0.delete();
            q1.delete();
        end else begin
            if (q0.size() != 0) void'(q0.pop_front());
            else if (start)     q0 = build(ir, 16, 1);
            if (q1.size() != 0) void'(q1.pop_front());
            else if (start)     q1 = build(ir, 8, 4);
        end
    end

    function automatic out_t expv(input int k);
        if (k == 0) return (q0.size() != 0) ? q0[0] : '0;
        return (q1.size() != 0) ? q1[0] : '0;
    endfunction

    // Small datapath driven by each instance's strobes, for end-to-end results
    logic [31:0] R [2][16];
    logic [31:0] Y [2];
    logic [31:0] LO [2];
    logic [31:0] HI [2];
    logic [63:0] Z [2];
    logic [31:0] init_R [16];
    logic        do_init = 1'b0;

    always @(negedge clock) begin : datapath
        logic [31:0] bus;
        out_t        o;
        for (int k = 0; k < 2; k++) begin
            o = obs[k];
            if (do_init) for (int j = 0; j < 16; j++) R[k][j] = init_R[j];
            bus = 32'h0;
            for (int j = 0; j < 16; j++) if (o.rout[j]) bus = R[k][j];
            if (o.zlo_out) bus = Z[k][31:0];
            if (o.zhi_out) bus = Z[k][63:32];
            if (o.zlo_in || o.zhi_in) begin
                if (o.alu_mul)          Z[k] = {32'h0, Y[k]} * {32'h0, bus};
                else if (o.alu_div)     Z[k] = {Y[k] % bus, Y[k] / bus};
                else if (o.alu_op == 5) Z[k] = {32'h0, Y[k] >> bus};
                else                    Z[k] = {32'h0, Y[k] + bus};
            end
            if (o.y_in) Y[k] = bus;
            for (int j = 0; j < 16; j++) if (o.rin[j]) R[k][j] = bus;
            if (o.lo_in) LO[k] = bus;
            if (o.hi_in) HI[k] = bus;
        end
    end

    task automatic preset(input int a, input logic [31:0] va, input int b, input logic [31:0] vb);
        for (int j = 0; j < 16; j++) init_R[j] = 32'h0;
        init_R[a] = va;
        init_R[b] = vb;
        do_init = 1'b1;
        @(negedge clock);
        #1 do_init = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; ir = 32'h0;
        repeat (2) @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== '0) begin
                errors++; $display("FAIL reset_outputs inst%0d: got %h expected 0", k, obs[k]);
            end
        end
        ir = mk_ir(0, 1, 2, 3);
        clear = 1'b0; start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock); start = 1'b0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    errors++; $display("FAIL first_start inst%0d cycle %0d: got %h expected %h", k, c, obs[k], expv(k));
                end
            end
        end
    endtask

    task automatic test_shr();
        preset(0, 32'h34, 4, 32'h2);
        ir = mk_ir(5, 7, 0, 4); start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock); start = 1'b0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    errors++; $display("FAIL shr_trace inst%0d cycle %0d: got %h expected %h", k, c, obs[k], expv(k));
                end
            end
            if (c == 5) begin
                checks++;
                if (!(obs[0].done === 1'b1 && obs[0].rin === 16'h0080)) begin
                    errors++; $display("FAIL shr_t5 done=%b rin=%h expected done=1 rin=0080", obs[0].done, obs[0].rin);
                end
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (R[k][7] !== 32'h0000000D) begin
                errors++; $display("FAIL shr_result inst%0d: R7=%h expected 0000000d", k, R[k][7]);
            end
        end
    endtask

    task automatic test_muldiv(input int op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] lo_exp, input logic [31:0] hi_exp);
        int div_cnt = 0, div_first = -1, z_idx = -1;
        preset(2, a, 3, b);
        ir = mk_ir(op, 1, 2, 3); start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock); start = 1'b0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    errors++; $display("FAIL muldiv%0d_trace inst%0d cycle %0d: got %h expected %h", op, k, c, obs[k], expv(k));
                end
            end
            if (ALU_DIV_1 === 1'b1) begin
                div_cnt++;
                if (div_first < 0) div_first = c;
            end
            if (Zlowin_1 === 1'b1 && ALU_DIV_1 === 1'b1) z_idx = c;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (LO[k] !== lo_exp || HI[k] !== hi_exp) begin
                errors++; $display("FAIL muldiv%0d_result inst%0d: LO=%h HI=%h expected LO=%h HI=%h", op, k, LO[k], HI[k], lo_exp, hi_exp);
            end
        end
        if (op == 13) begin
            checks++;
            if (div_cnt != 4 || z_idx != div_first + 3) begin
                errors++; $display("FAIL div_latency: div_cycles=%0d zlowin_at=%0d expected 4 and %0d", div_cnt, z_idx, div_first + 3);
            end
        end
    endtask

    task automatic test_illegal(input logic [31:0] irv, input bit ill0);
        bit rin_seen [2] = '{0, 0};
        ir = irv; start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock); start = 1'b0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    errors++; $display("FAIL illegal_trace inst%0d cycle %0d: got %h expected %h", k, c, obs[k], expv(k));
                end
                if (obs[k].rin != 16'h0) rin_seen[k] = 1'b1;
            end
            if (c == 3) begin
                checks++;
                if (illegal_0 !== ill0 || illegal_1 !== 1'b1) begin
                    errors++; $display("FAIL illegal_pulse: got %b/%b expected %b/1", illegal_0, illegal_1, ill0);
                end
            end
        end
        checks++;
        if (rin_seen[1] || (ill0 && rin_seen[0])) begin
            errors++; $display("FAIL illegal_no_rin: rin seen %b/%b expected none on illegal", rin_seen[0], rin_seen[1]);
        end
    endtask

    task automatic test_clear_mid_wait();
        bit wr_seen = 1'b0;
        preset(2, 32'd17, 3, 32'd5);
        ir = mk_ir(13, 1, 2, 3); start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock); start = 1'b0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    errors++; $display("FAIL clear_pre inst%0d cycle %0d: got %h expected %h", k, c, obs[k], expv(k));
                end
            end
        end
        #2 clear = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs[k] !== '0) begin
                errors++; $display("FAIL clear_async inst%0d: got %h expected 0", k, obs[k]);
            end
        end
        @(negedge clock);
        clear = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    errors++; $display("FAIL clear_post inst%0d cycle %0d: got %h expected %h", k, c, obs[k], expv(k));
                end
                if (obs[k].lo_in || obs[k].hi_in || obs[k].rin != 16'h0) wr_seen = 1'b1;
            end
        end
        checks++;
        if (wr_seen) begin
            errors++; $display("FAIL clear_no_resume: write strobe seen=1 expected 0");
        end
    endtask

    task automatic test_random(input int iters);
        for (int n = 0; n < iters; n++) begin
            ir = mk_ir($urandom_range(0, 15), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9))
                 | ($urandom & 32'h0000_7FFF);
            start = 1'b1;
            for (int c = 0; c < 11; c++) begin
                @(negedge clock); start = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (obs[k] !== expv(k)) begin
                        errors++; $display("FAIL random_trace ir=%h inst%0d cycle %0d: got %h expected %h", ir, k, c, obs[k], expv(k));
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int low_run [2]  = '{0, 0};
        bit seen_busy [2] = '{0, 0};
        ir = mk_ir(12, 1, 2, 3); start = 1'b1;
        for (int c = 0; c < 57; c++) begin
            @(negedge clock);
            if (c == 45) start = 1'b0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv(k)) begin
                    errors++; $display("FAIL b2b_trace inst%0d cycle %0d: got %h expected %h", k, c, obs[k], expv(k));
                end
                checks++;
                if ($countones(obs[k].rin) > 1 || $countones(obs[k].rout) > 1 ||
                    (obs[k].rin != 16'h0 && obs[k].rout != 16'h0) || (obs[k].done && obs[k].illegal)) begin
                    errors++; $display("FAIL b2b_exclusive inst%0d cycle %0d: rin=%h rout=%h done=%b illegal=%b expected one-hot exclusive",
                                       k, c, obs[k].rin, obs[k].rout, obs[k].done, obs[k].illegal);
                end
                if (obs[k].busy) begin
                    if (seen_busy[k] && low_run[k] != 0 && c < 45) begin
                        checks++;
                        if (low_run[k] != 1) begin
                            errors++; $display("FAIL b2b_gap inst%0d cycle %0d: idle gap %0d expected 1", k, c, low_run[k]);
                        end
                    end
                    seen_busy[k] = 1'b1;
                    low_run[k]   = 0;
                end else begin
                    low_run[k]++;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_shr();
        test_muldiv(12, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001);
        test_muldiv(13, 32'd17, 32'd5, 32'd3, 32'd2);
        test_illegal(mk_ir(20, 1, 2, 3), 1'b1);
        test_illegal(mk_ir(0, 9, 1, 2), 1'b0);
        test_clear_mid_wait();
        test_random(25);
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
